// File: rtl/wdt_pkg.sv
// Shared watchdog command definitions, used by the bus-side transmitter
// and the clk2-side command decoder.
package wdt_pkg;

   localparam int WDT_PKT_W = 34;

   typedef enum logic [1:0] {
      CMD_EN    = 2'd0,
      CMD_LIVE  = 2'd1,
      CMD_TOCNT = 2'd2
   } cmd_t;

   localparam logic [1:0] ADDR_WDEN   = 2'd0;
   localparam logic [1:0] ADDR_WDLIVE = 2'd1;
   localparam logic [1:0] ADDR_WTOCNT = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   typedef struct packed {
      cmd_t        cmd;
      logic [31:0] payload;
   } wdt_pkt_t;

   typedef enum logic {
      SLOT_IDLE   = 1'b0,
      SLOT_LOADED = 1'b1
   } slot_state_t;

endpackage

// File: rtl/wdt_cmd_fifo.sv
// Synchronous DEPTH x WDT_PKT_W command queue; the head is presented on dout
// while not empty. Push when full and pop when empty are ignored.
module wdt_cmd_fifo
   import wdt_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [WDT_PKT_W-1:0] din,
   input  logic                 pop,
   output logic [WDT_PKT_W-1:0] dout,
   output logic                 full,
   output logic                 empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WDT_PKT_W-1:0] mem [DEPTH];
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;

   // Extra pointer bit distinguishes full from empty when the indices match.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop && !empty)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push && !full)
         mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/wdt_cmd_tx.sv
// Bus-side watchdog command transmitter: register writes become ordered
// packets pushed into the AFIFO; WTO is synchronized back into clk.
module wdt_cmd_tx
   import wdt_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        reg_req,
   input  logic        reg_we,
   input  logic [1:0]  reg_addr,
   input  logic [31:0] reg_wdata,
   output logic        reg_ready,
   output logic        reg_rvalid,
   output logic [31:0] reg_rdata,
   output logic        afifo_wpush,
   output logic [33:0] afifo_wdata,
   input  logic        afifo_wfull,
   input  logic        wto_async,
   output logic        wto_sync,
   output logic        wto_rise
);

   // Handshake: a register access completes on an edge where reg_req &
   // reg_ready; a packet is consumed on an edge where afifo_wpush & !afifo_wfull.

   logic        q_push, q_pop, q_full, q_empty;
   wdt_pkt_t    q_din, q_dout, slot_pkt;
   slot_state_t state, state_nxt;
   logic        wden_shadow;
   logic [31:0] tocnt_shadow;
   logic        wr_acc, rd_acc, slot_valid, consumed;
   logic        wto_meta, wto_sync_d;

   assign reg_ready = !(reg_we && q_full);
   assign wr_acc    = reg_req && reg_we && !q_full;
   assign rd_acc    = reg_req && !reg_we;

   always_comb begin
      q_push        = 1'b0;
      q_din.cmd     = CMD_EN;
      q_din.payload = '0;
      if (wr_acc) begin
         case (reg_addr)
            ADDR_WDEN: begin
               q_push        = 1'b1;
               q_din.payload = {31'b0, reg_wdata[0]};
            end
            ADDR_WDLIVE: begin
               q_push    = reg_wdata[0];
               q_din.cmd = CMD_LIVE;
            end
            ADDR_WTOCNT: begin
               q_push        = 1'b1;
               q_din.cmd     = CMD_TOCNT;
               q_din.payload = reg_wdata;
            end
            default: ;
         endcase
      end
   end

   wdt_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (q_push),
      .din   (q_din),
      .pop   (q_pop),
      .dout  (q_dout),
      .full  (q_full),
      .empty (q_empty)
   );

   assign slot_valid  = (state == SLOT_LOADED);
   assign consumed    = slot_valid && !afifo_wfull;
   assign afifo_wpush = slot_valid;
   assign afifo_wdata = slot_pkt;

   // Slot reloads from the queue head in the same cycle it is consumed,
   // giving one packet per cycle while the AFIFO accepts.
   always_comb begin
      state_nxt = state;
      q_pop     = 1'b0;
      case (state)
         SLOT_IDLE: begin
            if (!q_empty) begin
               q_pop     = 1'b1;
               state_nxt = SLOT_LOADED;
            end
         end
         SLOT_LOADED: begin
            if (consumed) begin
               if (!q_empty) q_pop = 1'b1;
               else          state_nxt = SLOT_IDLE;
            end
         end
         default: state_nxt = SLOT_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= SLOT_IDLE;
         slot_pkt <= '0;
      end else begin
         state <= state_nxt;
         if (q_pop)
            slot_pkt <= q_dout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wden_shadow  <= 1'b0;
         tocnt_shadow <= '0;
         reg_rvalid   <= 1'b0;
         reg_rdata    <= '0;
      end else begin
         if (wr_acc && reg_addr == ADDR_WDEN)
            wden_shadow <= reg_wdata[0];
         if (wr_acc && reg_addr == ADDR_WTOCNT)
            tocnt_shadow <= reg_wdata;
         reg_rvalid <= rd_acc;
         if (rd_acc) begin
            case (reg_addr)
               ADDR_WDEN:   reg_rdata <= {31'b0, wden_shadow};
               ADDR_WTOCNT: reg_rdata <= tocnt_shadow;
               ADDR_STATUS: reg_rdata <= {29'b0, q_empty && !slot_valid, slot_valid, wto_sync};
               default:     reg_rdata <= '0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wto_meta   <= 1'b0;
         wto_sync   <= 1'b0;
         wto_sync_d <= 1'b0;
         wto_rise   <= 1'b0;
      end else begin
         wto_meta   <= wto_async;
         wto_sync   <= wto_meta;
         wto_sync_d <= wto_sync;
         wto_rise   <= wto_sync && !wto_sync_d;
      end
   end

endmodule

// File: tb/tb_wdt_cmd_tx.sv
// Directed bench for wdt_cmd_tx: stimulus pushes expected packets/read data
// into queues; a negedge monitor pops and compares on every DUT output.
module tb_wdt_cmd_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        reg_req = 1'b0;
   logic        reg_we = 1'b0;
   logic [1:0]  reg_addr = 2'd0;
   logic [31:0] reg_wdata = '0;
   logic        reg_ready, reg_rvalid;
   logic [31:0] reg_rdata;
   logic        afifo_wpush;
   logic [33:0] afifo_wdata;
   logic        afifo_wfull = 1'b0;
   logic        wto_async = 1'b0;
   logic        wto_sync, wto_rise;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int last_acc = 0;
   int a0, r0;
   logic [33:0] exp_q[$];
   logic [31:0] rd_q[$];
   int          cons_q[$];

   wdt_cmd_tx #(.DEPTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .reg_req     (reg_req),
      .reg_we      (reg_we),
      .reg_addr    (reg_addr),
      .reg_wdata   (reg_wdata),
      .reg_ready   (reg_ready),
      .reg_rvalid  (reg_rvalid),
      .reg_rdata   (reg_rdata),
      .afifo_wpush (afifo_wpush),
      .afifo_wdata (afifo_wdata),
      .afifo_wfull (afifo_wfull),
      .wto_async   (wto_async),
      .wto_sync    (wto_sync),
      .wto_rise    (wto_rise)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (afifo_wpush && !afifo_wfull) begin
            if (exp_q.size() == 0)
               chk("unexpected_push", afifo_wdata, 34'h3_ffff_ffff);
            else begin
               chk("pkt", afifo_wdata, exp_q.pop_front());
               cons_q.push_back(cyc + 1);
            end
         end
         if (reg_rvalid) begin
            if (rd_q.size() == 0)
               chk("unexpected_rvalid", {2'b0, reg_rdata}, 34'h3_ffff_ffff);
            else
               chk("rdata", {2'b0, reg_rdata}, {2'b0, rd_q.pop_front()});
         end
      end
   end

   // drivers: all start and end at posedge+1
   task automatic do_write(input logic [1:0] a, input logic [31:0] d,
                           input bit has_pkt, input logic [33:0] pkt);
      bit acc = 1'b0;
      reg_req = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = reg_ready;
         @(posedge clk); #1;
      end
      reg_req = 1'b0; reg_we = 1'b0;
      if (!acc) begin
         total++; bad++;
         $display("FAIL write_timeout: addr %0d not accepted in 200 cycles", a);
      end else begin
         last_acc = cyc;
         if (has_pkt) exp_q.push_back(pkt);
      end
   endtask

   task automatic do_read(input logic [1:0] a, input logic [31:0] exp);
      reg_req = 1'b1; reg_we = 1'b0; reg_addr = a;
      @(posedge clk); #1;
      reg_req = 1'b0;
      rd_q.push_back(exp);
      @(negedge clk);
      chk("rvalid_latency", {33'b0, reg_rvalid}, 34'd1);
      @(posedge clk); #1;
   endtask

   task automatic wait_idle();
      bit done = 1'b0;
      for (int i = 0; i < 300 && !done; i++) begin
         @(negedge clk);
         done = (exp_q.size() == 0) && !afifo_wpush;
      end
      @(posedge clk); #1;
      if (!done) begin
         total++; bad++;
         $display("FAIL drain_timeout: %0d packets still expected", exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not finish");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1);
   end

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_wpush",  {33'b0, afifo_wpush}, 34'd0);
      chk("rst_wdata",  afifo_wdata, 34'd0);
      chk("rst_rvalid", {33'b0, reg_rvalid}, 34'd0);
      chk("rst_rdata",  {2'b0, reg_rdata}, 34'd0);
      chk("rst_wto",    {32'b0, wto_sync, wto_rise}, 34'd0);
      chk("rst_ready",  {33'b0, reg_ready}, 34'd1);
      rst = 1'b0;
      @(posedge clk); #1;

      // back-to-back packets, 2-cycle latency
      cons_q.delete();
      do_write(2'd2, 32'h0000_0010, 1'b1, {2'd2, 32'h0000_0010});
      a0 = last_acc;
      do_write(2'd0, 32'h0000_0001, 1'b1, {2'd0, 32'h0000_0001});
      wait_idle();
      chk("t1_npkts", cons_q.size(), 34'd2);
      if (cons_q.size() == 2) begin
         chk("t1_first_lat", cons_q[0], a0 + 2);
         chk("t1_second_lat", cons_q[1], a0 + 3);
      end

      // fill under backpressure, then release
      afifo_wfull = 1'b1;
      do_write(2'd2, 32'h0000_0100, 1'b1, {2'd2, 32'h0000_0100});
      do_write(2'd2, 32'h0000_0200, 1'b1, {2'd2, 32'h0000_0200});
      do_write(2'd1, 32'h0000_0001, 1'b1, {2'd1, 32'h0000_0000});
      do_write(2'd0, 32'h0000_0000, 1'b1, {2'd0, 32'h0000_0000});
      do_write(2'd2, 32'h0000_0300, 1'b1, {2'd2, 32'h0000_0300});
      reg_req = 1'b1; reg_we = 1'b1; reg_addr = 2'd2; reg_wdata = 32'h0000_0400;
      @(negedge clk);
      chk("t2_ready_full", {33'b0, reg_ready}, 34'd0);
      chk("t2_hold_push", {33'b0, afifo_wpush}, 34'd1);
      chk("t2_hold_data", afifo_wdata, {2'd2, 32'h0000_0100});
      @(posedge clk); #1;
      reg_req = 1'b0; reg_we = 1'b0;
      cons_q.delete();
      r0 = cyc;
      afifo_wfull = 1'b0;
      wait_idle();
      chk("t2_npkts", cons_q.size(), 34'd5);
      if (cons_q.size() == 5)
         for (int i = 0; i < 5; i++) chk("t2_rate", cons_q[i], r0 + 1 + i);

      // WDLIVE=0 makes no packet
      cons_q.delete();
      do_write(2'd1, 32'h0000_0000, 1'b0, '0);
      do_write(2'd1, 32'h0000_0001, 1'b1, {2'd1, 32'h0000_0000});
      wait_idle();
      chk("t3_npkts", cons_q.size(), 34'd1);

      // register reads
      do_write(2'd2, 32'hDEAD_BEEF, 1'b1, {2'd2, 32'hDEAD_BEEF});
      wait_idle();
      do_read(2'd2, 32'hDEAD_BEEF);
      do_read(2'd3, 32'h0000_0004);
      do_read(2'd0, 32'h0000_0000);
      do_read(2'd1, 32'h0000_0000);

      // WTO synchronizer
      wto_async = 1'b1;
      @(negedge clk);
      chk("t5_sync_e0", {32'b0, wto_sync, wto_rise}, 34'd0);
      @(negedge clk);
      chk("t5_sync_e1", {32'b0, wto_sync, wto_rise}, 34'd0);
      @(negedge clk);
      chk("t5_sync_e2", {32'b0, wto_sync, wto_rise}, 34'b10);
      @(negedge clk);
      chk("t5_rise_e3", {32'b0, wto_sync, wto_rise}, 34'b11);
      @(negedge clk);
      chk("t5_rise_e4", {32'b0, wto_sync, wto_rise}, 34'b10);
      @(posedge clk); #1;
      do_read(2'd3, 32'h0000_0005);
      wto_async = 1'b0;
      repeat (4) @(posedge clk);
      #1;

      // reset with commands in flight
      afifo_wfull = 1'b1;
      do_write(2'd0, 32'h0000_0001, 1'b0, '0);
      do_write(2'd2, 32'h0000_0055, 1'b0, '0);
      do_write(2'd1, 32'h0000_0001, 1'b0, '0);
      do_write(2'd2, 32'h0000_0066, 1'b0, '0);
      @(negedge clk);
      chk("t6_push_before", {33'b0, afifo_wpush}, 34'd1);
      #2 rst = 1'b1;
      #1;
      chk("t6_push_async_clr", {33'b0, afifo_wpush}, 34'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      afifo_wfull = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      do_read(2'd0, 32'h0000_0000);
      do_read(2'd2, 32'h0000_0000);
      do_read(2'd3, 32'h0000_0004);
      repeat (2) @(posedge clk);
      chk("end_exp_empty", exp_q.size(), 34'd0);
      chk("end_rd_empty", rd_q.size(), 34'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/wdt_cmd_tx.md
# wdt_cmd_tx

Bus-side (clk domain) command transmitter for the watchdog timer. Converts CPU register writes to WDEN, WDLIVE and WTOCNT into ordered command packets and pushes them into the write port of the async FIFO that feeds the clk2-domain watchdog. It also brings the watchdog's timeout (WTO) back into the clk domain as a synchronized level, a rise pulse and a status bit. It sits between the bus slave wrapper and the AFIFO write side.

## Interface
- DEPTH, 4: local command queue entries (power of two, ≥2)
- clk  in  1  bus/CPU clock
- rst  in  1  asynchronous, active-high reset
- reg_req  in  1  register access request
- reg_we  in  1  1 = write, 0 = read
- reg_addr  in  2  0 WDEN, 1 WDLIVE, 2 WTOCNT, 3 STATUS
- reg_wdata  in  32  write data
- reg_ready  out  1  access accepted this cycle when reg_req & reg_ready
- reg_rvalid  out  1  read data valid (one-cycle pulse)
- reg_rdata  out  32  read data
- afifo_wpush  out  1  packet valid toward AFIFO
- afifo_wdata  out  34  {cmd[1:0], payload[31:0]}
- afifo_wfull  in  1  AFIFO full; push is consumed at an edge where afifo_wpush & !afifo_wfull
- wto_async  in  1  WTO from clk2 domain (unsynchronized)
- wto_sync  out  1  synchronized WTO level
- wto_rise  out  1  one-cycle pulse on wto_sync 0→1

## Operation
- Commands: CMD_EN=0 (payload[0] = enable), CMD_LIVE=1 (payload 0), CMD_TOCNT=2 (payload = reload value).
- Writes are accepted when reg_req & reg_we & reg_ready.
  - addr0: enqueue CMD_EN with {31'b0, wdata[0]}; update wden_shadow.
  - addr1: enqueue CMD_LIVE only if wdata[0]=1; a write of 0 is accepted but produces no command.
  - addr2: enqueue CMD_TOCNT with wdata; update tocnt_shadow.
  - addr3: accepted and ignored.
- Reads are always accepted (reg_ready is 1 for reads).
  - addr0 → {31'b0, wden_shadow}
  - addr1 → 0
  - addr2 → tocnt_shadow
  - addr3 → {29'b0, queue_empty & !slot_valid, slot_valid, wto_sync}
- reg_ready for writes = !queue_full. Stalled writes hold until the queue has space.
- Output slot (registered afifo_wpush/afifo_wdata) has two states:
  - IDLE → LOADED when the queue is non-empty; the head is popped into the slot.
  - LOADED → IDLE when the push is consumed and the queue is empty.
  - LOADED → LOADED (reload from the next head in the same cycle) when the push is consumed and the queue is non-empty. This gives back-to-back pushes at one packet per cycle.
  - LOADED holds data and afifo_wpush stable while afifo_wfull=1.
- Strict FIFO ordering end to end. No coalescing or dropping.
- WTO path: 2-flop synchronizer, then wto_sync; wto_rise = wto_sync & !wto_sync_d.

## Timing
- Reset values: afifo_wpush=0, afifo_wdata=0, reg_rvalid=0, reg_rdata=0, wto_sync=0, wto_rise=0, reg_ready=1, shadows=0, queue empty, slot IDLE.
- Write accepted at edge E0 with queue empty and wfull=0 → afifo_wpush=1 after E1, consumed at E2. Minimum latency is 2 cycles.
- Read accepted at E0 → reg_rvalid=1 with data for the cycle after E0.
- A write to an empty queue while the slot is consumed: the entry bypasses nothing; it goes through the queue (no shortcut).
- Queue full with a pop in the same cycle: reg_ready stays 0 that cycle, since ready is computed from registered full.
- wto_async rise → wto_sync high 2 edges later; wto_rise is high 3 edges later for one cycle.
- rst asserted mid-operation: queue, slot and shadows are cleared immediately (async). Commands in flight are lost. The AFIFO is reset by the same system reset.

## Structure
- wdt_pkg:
  - cmd_t enum (CMD_EN, CMD_LIVE, CMD_TOCNT)
  - address constants ADDR_WDEN/WDLIVE/WTOCNT/STATUS
  - WDT_PKT_W=34
  - packet struct {cmd_t cmd; logic [31:0] payload;}
  - Shared with the clk2-side command decoder.
- Sub-module wdt_cmd_fifo: synchronous DEPTH×34 FIFO with push, pop, full and empty outputs.
- The top holds the register decode, shadows, slot FSM and WTO synchronizer.

## Test plan
- Write WTOCNT=0x0000_0010, then WDEN=1, with wfull=0 → pushes {2,0x10} then {0,1} on consecutive cycles; the first push is 2 cycles after accept.
- Hold wfull=1 and issue 5 writes (DEPTH=4) → 4 queued plus 1 in the slot. The next write sees reg_ready=0. Release wfull → 5 packets in order, one per cycle.
- Write WDLIVE=0, then WDLIVE=1 → exactly one {1,0} packet.
- Read addr2 after WTOCNT=0xDEAD_BEEF → reg_rvalid next cycle with rdata=0xDEAD_BEEF. Read addr3 with everything idle → 0x4.
- Raise wto_async → wto_sync high 2 cycles later; wto_rise is a single pulse; STATUS bit0=1.
- Assert rst with 3 queued commands and wfull=1 → afifo_wpush drops immediately. After release, no stale packets are pushed.
